timer_irq_src: RTL and testbench
================================

Name: timer_irq_src

Overview:
- Memory-mapped countdown timer that sits upstream of the CPU core and drives its `interrupt` input.
- The CPU programs it through the system bridge: word-addressed register file, single-cycle write, combinational read.
- Supports a one-shot mode and a periodic auto-reload mode, with an interrupt mask.

Parameters:
DW, 32, data width of the PRESET/COUNT registers and the bus data ports.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
addr  input  2  word offset: 0=CTRL, 1=PRESET, 2=COUNT, 3=unmapped.
we  input  1  write enable; the write commits at the rising edge.
din  input  DW  write data.
dout  output  DW  combinational read data for `addr`.
irq  output  1  interrupt request to the CPU; equals irq_flag AND CTRL.IM.

Behaviour:
Registers and reset
- CTRL[3:0] fields:
  - bit0 EN: count enable.
  - bits2:1 MODE: 00 one-shot, 01 periodic, 10/11 treated as one-shot.
  - bit3 IM: interrupt mask, 1 = unmasked.
- CTRL bits 31:4 are not stored and read 0.
- PRESET is a DW-bit reload value, read/write.
- COUNT is the DW-bit current count. It is read-only; writes to it are ignored.
- addr 3 reads 0; writes to it are ignored.
- Reset (async) clears: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE. Therefore irq=0 and dout=0 at addr 0.

State machine
- States: IDLE, LOAD, CNT, INT. The FSM evaluates the pre-edge CTRL value; a CTRL write and an FSM transition at the same edge both take effect, and the FSM sees the old CTRL.
- IDLE: EN=1 -> LOAD; otherwise stay. COUNT holds.
- LOAD: COUNT<=PRESET -> CNT.
- CNT:
  - EN=0 -> IDLE, COUNT holds its value.
  - Else if COUNT<=1: COUNT<=0, irq_flag<=1, -> INT.
  - Else COUNT<=COUNT-1.
- INT, one-shot: CTRL.EN<=0 -> IDLE. irq_flag stays 1 until software writes CTRL or PRESET; that write clears irq_flag at the same edge.
- INT, periodic: irq_flag<=0 -> LOAD, so the flag is high for exactly one cycle. If EN was cleared by software, go to IDLE instead.
- If a CTRL write sets EN at the same edge that INT clears EN in one-shot mode, the software write wins and EN=1.

Timing
- Enabling write at edge 0 with PRESET=N, N>=1:
  - LOAD at edge 1.
  - COUNT=N at edge 2.
  - COUNT=N-k at edge 2+k.
  - irq_flag rises at edge N+2.
- N=0 gives irq at edge 3, the same as N=1.
- Periodic interrupt period is N+2 cycles.

Write and read rules
- A PRESET write during CNT does not disturb the current count; it applies at the next LOAD.
- Writing EN=0 during CNT freezes COUNT (IDLE at the next edge). Re-enabling reloads from PRESET; it does not resume.
- Wrap-around cannot occur: COUNT never decrements below 0.
- An async reset mid-count returns everything to its reset values immediately, and irq deasserts without waiting for a clock.
- dout is purely combinational from addr and the current register values; there is no read side effect.

Test Plan:
- Reset values: assert reset for 3 cycles, release -> irq=0; dout=0 at addr 0, 1 and 2; writes to addr 2 and addr 3 leave all reads 0.
- One-shot: write PRESET=5, then CTRL=0x9 at edge 0 -> COUNT reads 5,4,3,2,1 at edges 2..6; irq=1 at edge 7 and stays high; CTRL reads 0x8 (EN cleared); writing CTRL=0x8 drops irq at the next edge.
- Periodic: PRESET=3, CTRL=0xB -> irq is a 1-cycle pulse at edges 5, 10 and 15 (period 5); CTRL.EN stays 1.
- Masking and zero preset: PRESET=0, CTRL=0x1 (IM=0) -> irq_flag is set at edge 3 but the irq pin stays 0; writing CTRL=0x8 clears the flag, and irq stays 0.
- Pause and preset update: PRESET=10, enable, clear EN when COUNT=6 -> COUNT holds 6 in IDLE; write PRESET=2, re-enable -> COUNT reloads to 2 and irq arrives 4 cycles after the re-enable write edge.
- Reset mid-operation: PRESET=4, start periodic, assert reset while COUNT=2 -> irq, COUNT and CTRL are 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/timer_irq_src_if.sv
`default_nettype none
// ============================================================================
// Module    : timer_irq_src_if
// Purpose   : Register-bus bundle between the system bridge and the
//             timer_irq_src countdown timer.
// Signals   : addr  - word offset (0=CTRL, 1=PRESET, 2=COUNT, 3=unmapped)
//             we    - write enable, write commits at the rising clock edge
//             din   - write data
//             dout  - combinational read data for addr
//             irq   - interrupt request to the CPU
// Modports  : master - bridge / CPU side, drives addr/we/din
//             slave  - timer side, drives dout/irq
// Revision  : 1.0 - initial release
// ============================================================================
interface timer_irq_src_if #(
   parameter int DW = 32
);
   logic [1:0]    addr;
   logic          we;
   logic [DW-1:0] din;
   logic [DW-1:0] dout;
   logic          irq;

   modport master (
      output addr,
      output we,
      output din,
      input  dout,
      input  irq
   );

   modport slave (
      input  addr,
      input  we,
      input  din,
      output dout,
      output irq
   );
endinterface
`default_nettype wire

// File: rtl/timer_irq_src.sv
`default_nettype none
// ============================================================================
// Module    : timer_irq_src
// Purpose   : Memory-mapped countdown timer driving the CPU interrupt line.
//             One-shot and periodic auto-reload modes with an interrupt mask.
// Ports     : clk    - system clock, all state changes on the rising edge
//             reset  - asynchronous, active-high reset
//             bus    - timer_irq_src_if.slave register bus
//                      (addr, we, din -> in; dout, irq -> out)
// Registers : 0 CTRL   [0] EN, [2:1] MODE (01 periodic, else one-shot),
//                      [3] IM (1 = unmasked); bits 31:4 read 0
//             1 PRESET reload value, read/write
//             2 COUNT  current count, read-only
//             3 unmapped, reads 0, writes ignored
// Revision  : 1.0 - initial release
// ============================================================================
module timer_irq_src #(
   parameter int DW = 32
) (
   input  wire logic     clk,
   input  wire logic     reset,
   timer_irq_src_if.slave bus
);

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_load = 2'd1;
   localparam logic [1:0] c_st_cnt  = 2'd2;
   localparam logic [1:0] c_st_int  = 2'd3;

   localparam logic [1:0] c_addr_ctrl   = 2'd0;
   localparam logic [1:0] c_addr_preset = 2'd1;
   localparam logic [1:0] c_addr_count  = 2'd2;

   localparam logic [1:0] c_mode_periodic = 2'b01;

   localparam logic [DW-1:0] c_one = {{(DW-1){1'b0}}, 1'b1};

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [1:0]    r_state;
   logic [1:0]    w_state_nxt;
   logic [3:0]    r_ctrl;
   logic [DW-1:0] r_preset;
   logic [DW-1:0] r_count;
   logic          r_irq_flag;

   // -------------------------------------------------------------------------
   // Decoded control fields and bus write strobes
   // -------------------------------------------------------------------------
   logic w_en;
   logic w_periodic;
   logic w_im;
   logic w_wr_ctrl;
   logic w_wr_preset;
   logic w_cnt_le1;

   assign w_en        = r_ctrl[0];
   assign w_periodic  = (r_ctrl[2:1] == c_mode_periodic);
   assign w_im        = r_ctrl[3];
   assign w_wr_ctrl   = bus.we && (bus.addr == c_addr_ctrl);
   assign w_wr_preset = bus.we && (bus.addr == c_addr_preset);
   // A count of 0 (PRESET=0) expires exactly like 1, so no wrap is possible.
   assign w_cnt_le1   = (r_count <= c_one);

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next-state logic. Decisions use the pre-edge CTRL value, so a CTRL
   // write landing on the same edge is only seen one cycle later.
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle: begin
            if (w_en) begin
               w_state_nxt = c_st_load;
            end
         end
         c_st_load: begin
            w_state_nxt = c_st_cnt;
         end
         c_st_cnt: begin
            if (!w_en) begin
               w_state_nxt = c_st_idle;
            end else if (w_cnt_le1) begin
               w_state_nxt = c_st_int;
            end
         end
         c_st_int: begin
            // Periodic mode reloads unless software has dropped EN meanwhile.
            if (w_periodic && w_en) begin
               w_state_nxt = c_st_load;
            end else begin
               w_state_nxt = c_st_idle;
            end
         end
         default: begin
            w_state_nxt = c_st_idle;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: output decode
   // -------------------------------------------------------------------------
   logic w_load;          // copy PRESET into COUNT
   logic w_dec;           // decrement COUNT
   logic w_fire;          // COUNT expired: zero it and raise the flag
   logic w_oneshot_done;  // one-shot expiry: auto-clear EN
   logic w_period_done;   // periodic expiry: drop the flag after one cycle

   always_comb begin
      w_load         = 1'b0;
      w_dec          = 1'b0;
      w_fire         = 1'b0;
      w_oneshot_done = 1'b0;
      w_period_done  = 1'b0;
      case (r_state)
         c_st_load: begin
            w_load = 1'b1;
         end
         c_st_cnt: begin
            if (w_en) begin
               w_fire = w_cnt_le1;
               w_dec  = !w_cnt_le1;
            end
         end
         c_st_int: begin
            w_oneshot_done = !w_periodic;
            w_period_done  = w_periodic;
         end
         default: begin
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // CTRL: a software write takes priority over the one-shot EN auto-clear,
   // so re-arming on the expiry edge is never lost.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ctrl <= 4'd0;
      end else if (w_wr_ctrl) begin
         r_ctrl <= bus.din[3:0];
      end else if (w_oneshot_done) begin
         r_ctrl[0] <= 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // PRESET: only sampled at LOAD, so updates mid-count affect the next reload.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_preset <= '0;
      end else if (w_wr_preset) begin
         r_preset <= bus.din;
      end
   end

   // -------------------------------------------------------------------------
   // COUNT: read-only from the bus; holds in IDLE and INT.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (w_load) begin
         r_count <= r_preset;
      end else if (w_fire) begin
         r_count <= '0;
      end else if (w_dec) begin
         r_count <= r_count - c_one;
      end
   end

   // -------------------------------------------------------------------------
   // Interrupt flag: set on expiry; a CTRL or PRESET write acknowledges it;
   // in periodic mode it self-clears after a single cycle.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_irq_flag <= 1'b0;
      end else if (w_fire) begin
         r_irq_flag <= 1'b1;
      end else if (w_wr_ctrl || w_wr_preset || w_period_done) begin
         r_irq_flag <= 1'b0;
      end
   end

   assign bus.irq = r_irq_flag & w_im;

   // -------------------------------------------------------------------------
   // Read mux: purely combinational, no side effects.
   // -------------------------------------------------------------------------
   always_comb begin
      bus.dout = '0;
      case (bus.addr)
         c_addr_ctrl:   bus.dout[3:0] = r_ctrl;
         c_addr_preset: bus.dout      = r_preset;
         c_addr_count:  bus.dout      = r_count;
         default:       bus.dout      = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_timer_irq_src.sv
`default_nettype none
// ============================================================================
// Module    : tb_timer_irq_src
// Purpose   : Directed self-checking bench for timer_irq_src.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_timer_irq_src;

   localparam int DW = 32;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   timer_irq_src_if #(.DW(DW)) bus ();

   timer_irq_src #(.DW(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reg(input string tag, input logic [1:0] a, input logic [DW-1:0] exp);
      bus.addr = a;
      #1;
      chk(tag, bus.dout, exp);
   endtask

   task automatic chk_irq(input string tag, input logic exp);
      chk(tag, {{(DW-1){1'b0}}, bus.irq}, {{(DW-1){1'b0}}, exp});
   endtask

   // Advance n rising edges, return 1 time unit after the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Single write; it commits at the next rising edge, returns 1 unit after it.
   task automatic wr(input logic [1:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      bus.addr = a;
      bus.din  = d;
      bus.we   = 1'b1;
      @(posedge clk);
      #1;
      bus.we   = 1'b0;
      bus.din  = '0;
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      bus.addr = 2'd0;
      bus.we   = 1'b0;
      bus.din  = '0;

      // ---------------- reset values ----------------
      reset = 1'b1;
      tick(3);
      @(negedge clk);
      reset = 1'b0;
      tick(1);
      chk_irq("rst_irq", 1'b0);
      chk_reg("rst_ctrl", 2'd0, 32'h0);
      chk_reg("rst_preset", 2'd1, 32'h0);
      chk_reg("rst_count", 2'd2, 32'h0);
      wr(2'd2, 32'h1234_5678);
      wr(2'd3, 32'hFFFF_FFFF);
      chk_reg("ro_ctrl", 2'd0, 32'h0);
      chk_reg("ro_preset", 2'd1, 32'h0);
      chk_reg("ro_count", 2'd2, 32'h0);
      chk_reg("ro_unmapped", 2'd3, 32'h0);

      // ---------------- one-shot, PRESET=5 ----------------
      wr(2'd1, 32'd5);
      chk_reg("os_preset", 2'd1, 32'd5);
      wr(2'd0, 32'h9);                       // edge 0
      tick(1);                               // edge 1: LOAD
      for (int k = 0; k < 5; k++) begin
         tick(1);                            // edges 2..6
         chk_reg("os_count", 2'd2, 32'd5 - 32'(k));
         chk_irq("os_irq_low", 1'b0);
      end
      tick(1);                               // edge 7
      chk_irq("os_irq_rise", 1'b1);
      chk_reg("os_count_zero", 2'd2, 32'd0);
      tick(1);                               // edge 8: EN auto-cleared
      chk_reg("os_ctrl_en_clr", 2'd0, 32'h8);
      chk_irq("os_irq_sticky", 1'b1);
      tick(2);
      chk_irq("os_irq_sticky2", 1'b1);
      wr(2'd0, 32'h8);
      chk_irq("os_irq_ack", 1'b0);
      chk_reg("os_ctrl_after", 2'd0, 32'h8);

      // ---------------- periodic, PRESET=3 ----------------
      wr(2'd1, 32'd3);
      wr(2'd0, 32'hB);                       // edge 0
      for (int e = 1; e <= 16; e++) begin
         tick(1);
         chk_irq("per_irq", (e == 5) || (e == 10) || (e == 15));
      end
      chk_reg("per_ctrl", 2'd0, 32'hB);
      wr(2'd0, 32'h0);
      tick(2);
      chk_irq("per_stop_irq", 1'b0);

      // ---------------- masking and zero preset ----------------
      wr(2'd1, 32'd0);
      wr(2'd0, 32'h1);                       // edge 0
      tick(3);                               // edge 3: flag set, masked
      chk_irq("mask_irq", 1'b0);
      chk_reg("mask_count", 2'd2, 32'd0);
      tick(1);
      chk_reg("mask_ctrl", 2'd0, 32'h0);
      wr(2'd0, 32'h8);                       // unmask and acknowledge together
      chk_irq("mask_ack_irq", 1'b0);
      tick(2);
      chk_irq("mask_ack_irq2", 1'b0);

      // ---------------- pause and preset update ----------------
      wr(2'd1, 32'd10);
      wr(2'd0, 32'h9);                       // edge 0
      tick(5);                               // edge 5
      chk_reg("pause_count7", 2'd2, 32'd7);
      wr(2'd0, 32'h8);                       // edge 6: clear EN
      chk_reg("pause_count6", 2'd2, 32'd6);
      tick(1);
      chk_reg("pause_hold1", 2'd2, 32'd6);
      tick(2);
      chk_reg("pause_hold2", 2'd2, 32'd6);
      chk_irq("pause_irq", 1'b0);
      wr(2'd1, 32'd2);
      chk_reg("pause_preset_nodist", 2'd2, 32'd6);
      wr(2'd0, 32'h9);                       // re-enable edge 0
      tick(1);
      chk_reg("reen_load", 2'd2, 32'd6);
      tick(1);                               // edge 2
      chk_reg("reen_count2", 2'd2, 32'd2);
      tick(1);                               // edge 3
      chk_reg("reen_count1", 2'd2, 32'd1);
      chk_irq("reen_irq_low", 1'b0);
      tick(1);                               // edge 4
      chk_irq("reen_irq", 1'b1);
      wr(2'd0, 32'h0);
      tick(1);

      // ---------------- reset mid-operation ----------------
      wr(2'd1, 32'd4);
      wr(2'd0, 32'hB);                       // edge 0
      tick(4);                               // edge 4
      chk_reg("mid_count2", 2'd2, 32'd2);
      #2;
      reset = 1'b1;                          // between clock edges
      #1;
      chk_irq("mid_rst_irq", 1'b0);
      chk_reg("mid_rst_count", 2'd2, 32'd0);
      chk_reg("mid_rst_ctrl", 2'd0, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      // ---------------- async reset drops a raised irq ----------------
      wr(2'd1, 32'd1);
      wr(2'd0, 32'h9);                       // edge 0
      tick(3);                               // edge 3
      chk_irq("async_irq_high", 1'b1);
      #2;
      reset = 1'b1;
      #1;
      chk_irq("async_irq_drop", 1'b0);
      chk_reg("async_preset", 2'd1, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      tick(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
